// File: rtl/timer_dev.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT registers, a one-shot or
// auto-reload countdown FSM and a sticky interrupt flag driving irq.
module timer_dev #(
    parameter logic [2:0] WORD_MODE = 3'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        write_enable,
    input  logic [2:0]  mode,
    input  logic        stop,
    input  logic [31:0] write_data,
    output logic [31:0] read_result,
    output logic        valid,
    output logic        irq
);

    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

    state_t      state;
    logic        ctrl_en;
    logic [1:0]  ctrl_mode;
    logic        ctrl_im;
    logic [31:0] preset;
    logic [31:0] count;
    logic        pend;

    logic        off_ok;
    logic        wr_go;
    logic        auto_reload;
    logic [31:0] rd_mux;

    // Only the low nibble is decoded; the bridge has already matched the rest.
    logic unused_addr;
    assign unused_addr = ^addr[31:4];

    // COUNT is readable but not writable.
    always_comb begin
        off_ok = 1'b0;
        case (addr[3:2])
            2'd0, 2'd1: off_ok = 1'b1;
            2'd2:       off_ok = !write_enable;
            default:    off_ok = 1'b0;
        endcase
    end

    assign valid       = (mode == WORD_MODE) && (addr[1:0] == 2'b00) && off_ok;
    assign wr_go       = write_enable && valid && !stop;
    assign auto_reload = (ctrl_mode == 2'b01);

    always_comb begin
        rd_mux = 32'd0;
        case (addr[3:2])
            2'd0:    rd_mux = {28'd0, ctrl_im, ctrl_mode, ctrl_en};
            2'd1:    rd_mux = preset;
            2'd2:    rd_mux = count;
            default: rd_mux = 32'd0;
        endcase
    end

    assign read_result = valid ? rd_mux : 32'd0;
    assign irq         = ctrl_im && pend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ctrl_en   <= 1'b0;
            ctrl_mode <= 2'b00;
            ctrl_im   <= 1'b0;
            preset    <= 32'd0;
            count     <= 32'd0;
            pend      <= 1'b0;
        end else if (wr_go) begin
            // A software write restarts the timer from IDLE and acks any pending irq.
            state <= IDLE;
            pend  <= 1'b0;
            if (addr[3:2] == 2'd0) begin
                ctrl_en   <= write_data[0];
                ctrl_mode <= write_data[2:1];
                ctrl_im   <= write_data[3];
            end else begin
                preset <= write_data;
            end
        end else begin
            case (state)
                IDLE: if (ctrl_en) state <= LOAD;
                LOAD: begin
                    count <= preset;
                    state <= CNT;
                    if (auto_reload) pend <= 1'b0;
                end
                CNT: begin
                    if (!ctrl_en) begin
                        state <= IDLE;
                    end else if (count == 32'd0) begin
                        // PEND is registered on entry so irq covers both INT and LOAD.
                        state <= INT;
                        pend  <= 1'b1;
                    end else begin
                        count <= count - 32'd1;
                    end
                end
                INT: begin
                    pend <= 1'b1;
                    if (auto_reload) begin
                        state <= LOAD;
                    end else begin
                        ctrl_en <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_dev.sv
// Directed self-checking bench for timer_dev.
module tb_timer_dev;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic        write_enable;
    logic [2:0]  mode;
    logic        stop;
    logic [31:0] write_data;
    logic [31:0] read_result;
    logic        valid;
    logic        irq;

    int checks = 0;
    int errors = 0;

    timer_dev #(.WORD_MODE(3'd0)) dut (
        .clk(clk), .rst(rst), .addr(addr), .write_enable(write_enable),
        .mode(mode), .stop(stop), .write_data(write_data),
        .read_result(read_result), .valid(valid), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a; write_data = d; write_enable = 1'b1;
        tick();
        write_enable = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        addr = a; write_enable = 1'b0;
        #1;
        d = read_result;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1;
        #2;
        for (int i = 0; i < 3; i++) begin
            rd(32'(i * 4), d);
            checks++;
            if (d !== 32'd0) begin
                errors++; $display("FAIL reset_read[%0d] got %h want 0", i, d);
            end
        end
        checks++;
        if (irq !== 1'b0 || valid !== 1'b1) begin
            errors++; $display("FAIL reset_irq_valid got irq=%b valid=%b want 0/1", irq, valid);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_regs();
        logic [31:0] d;
        wr(32'h4, 32'hDEADBEEF);
        rd(32'h4, d);
        checks++;
        if (d !== 32'hDEADBEEF) begin
            errors++; $display("FAIL preset_rw got %h want deadbeef", d);
        end
        wr(32'h0, 32'hFFFF_FFF6);
        rd(32'h0, d);
        checks++;
        if (d !== 32'h6) begin
            errors++; $display("FAIL ctrl_rw got %h want 6", d);
        end
        wr(32'h0, 32'h0);
        rd(32'hC, d);
        checks++;
        if (d !== 32'd0 || valid !== 1'b0) begin
            errors++; $display("FAIL read_0xC got %h valid=%b want 0/0", d, valid);
        end
    endtask

    task automatic test_one_shot();
        logic [31:0] d;
        do_reset();
        wr(32'h4, 32'd5);
        wr(32'h0, 32'h9);
        for (int i = 1; i <= 7; i++) begin
            tick();
            if (i == 2) begin
                rd(32'h8, d);
                checks++;
                if (d !== 32'd5) begin
                    errors++; $display("FAIL os_count_load got %0d want 5", d);
                end
            end
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL os_irq_early got %b want 0", irq);
        end
        tick();
        checks++;
        if (irq !== 1'b1) begin
            errors++; $display("FAIL os_irq_rise got %b want 1", irq);
        end
        tick();
        tick();
        rd(32'h0, d);
        checks++;
        if (d !== 32'h8) begin
            errors++; $display("FAIL os_ctrl_en_clear got %h want 8", d);
        end
        rd(32'h8, d);
        checks++;
        if (d !== 32'd0 || irq !== 1'b1) begin
            errors++; $display("FAIL os_hold got count=%0d irq=%b want 0/1", d, irq);
        end
        wr(32'h0, 32'h8);
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL os_irq_ack got %b want 0", irq);
        end
    endtask

    task automatic test_auto_reload();
        logic [31:0] d;
        logic [31:0] exp_cnt [1:12];
        logic        exp_irq [1:12];
        exp_cnt = '{0, 2, 1, 0, 0, 0, 2, 1, 0, 0, 0, 2};
        exp_irq = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1, 0};
        do_reset();
        wr(32'h4, 32'd2);
        wr(32'h0, 32'hB);
        for (int i = 1; i <= 12; i++) begin
            tick();
            rd(32'h8, d);
            checks++;
            if (d !== exp_cnt[i] || irq !== exp_irq[i]) begin
                errors++;
                $display("FAIL ar_cycle%0d got count=%0d irq=%b want %0d/%b",
                         i, d, irq, exp_cnt[i], exp_irq[i]);
            end
        end
        wr(32'h0, 32'h0);
    endtask

    task automatic test_illegal();
        logic [31:0] d;
        do_reset();
        wr(32'h4, 32'h1234);
        addr = 32'h8; write_data = 32'hFFFF; write_enable = 1'b1;
        #1;
        checks++;
        if (valid !== 1'b0) begin
            errors++; $display("FAIL ill_wr8_valid got %b want 0", valid);
        end
        tick();
        addr = 32'h2;
        #1;
        checks++;
        if (valid !== 1'b0) begin
            errors++; $display("FAIL ill_wr2_valid got %b want 0", valid);
        end
        tick();
        addr = 32'h4; mode = 3'd2;
        #1;
        checks++;
        if (valid !== 1'b0) begin
            errors++; $display("FAIL ill_mode_valid got %b want 0", valid);
        end
        tick();
        mode = 3'd0; stop = 1'b1;
        tick();
        stop = 1'b0; write_enable = 1'b0;
        rd(32'h4, d);
        checks++;
        if (d !== 32'h1234) begin
            errors++; $display("FAIL ill_preset_kept got %h want 1234", d);
        end
        rd(32'h8, d);
        checks++;
        if (d !== 32'd0 || valid !== 1'b1) begin
            errors++; $display("FAIL ill_count_kept got %h valid=%b want 0/1", d, valid);
        end
    endtask

    task automatic test_collision();
        logic [31:0] d;
        do_reset();
        wr(32'h4, 32'd2);
        wr(32'h0, 32'h9);
        for (int i = 1; i <= 4; i++) tick();
        rd(32'h8, d);
        checks++;
        if (d !== 32'd0) begin
            errors++; $display("FAIL col_count_zero got %0d want 0", d);
        end
        wr(32'h0, 32'h8);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (irq !== 1'b0) begin
                errors++; $display("FAIL col_no_irq[%0d] got %b want 0", i, irq);
            end
            tick();
        end
        rd(32'h0, d);
        checks++;
        if (d !== 32'h8) begin
            errors++; $display("FAIL col_ctrl got %h want 8", d);
        end
    endtask

    task automatic test_reset_mid_count();
        logic [31:0] d;
        do_reset();
        wr(32'h4, 32'd6);
        wr(32'h0, 32'h9);
        for (int i = 1; i <= 5; i++) tick();
        rd(32'h8, d);
        checks++;
        if (d !== 32'd3) begin
            errors++; $display("FAIL rmc_count3 got %0d want 3", d);
        end
        rst = 1'b1;
        #0.5;
        for (int i = 0; i < 3; i++) begin
            rd(32'(i * 4), d);
            checks++;
            if (d !== 32'd0 || irq !== 1'b0) begin
                errors++; $display("FAIL rmc_async[%0d] got %h irq=%b want 0/0", i, d, irq);
            end
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        rd(32'h8, d);
        checks++;
        if (d !== 32'd0 || irq !== 1'b0) begin
            errors++; $display("FAIL rmc_no_resume got count=%0d irq=%b want 0/0", d, irq);
        end
    endtask

    initial begin
        rst = 1'b1; addr = '0; write_enable = 1'b0; mode = 3'd0;
        stop = 1'b0; write_data = '0;
        test_reset();
        test_regs();
        test_one_shot();
        test_auto_reload();
        test_illegal();
        test_collision();
        test_reset_mid_count();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/timer_dev.md
TIMER_DEV -- requirements
Module: timer_dev

Interface
REQ-001 SHALL have parameter WORD_MODE, default 3'd0, the mode code for a 32-bit word access; any other code is a sub-word access.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port addr, input, 32, bus address; only addr[3:0] is decoded, and the bridge decodes the upper bits.
REQ-005 SHALL have port write_enable, input, 1, write strobe from the CPU memory stage.
REQ-006 SHALL have port mode, input, 3, access width code.
REQ-007 SHALL have port stop, input, 1, squash: when 1, suppress any write this cycle (CPU exception flush).
REQ-008 SHALL have port write_data, input, 32, store data.
REQ-009 SHALL have port read_result, output, 32, combinational read data.
REQ-010 SHALL have port valid, output, 1, combinational access-legal flag.
REQ-011 SHALL have port irq, output, 1, interrupt request to one hwirq line.

Function
REQ-012 SHALL hold three registers:
- CTRL at offset 0x0: bit0 EN, bits2:1 MODE (00 one-shot, 01 auto-reload, 1x treated as one-shot), bit3 IM; bits31:4 read 0.
- PRESET at 0x4: 32-bit, read/write.
- COUNT at 0x8: 32-bit, read-only.
REQ-013 SHALL compute valid=1 only when mode==WORD_MODE, addr[1:0]==0, and the offset is 0x0/0x4/0x8 for reads or 0x0/0x4 for writes; otherwise valid=0.
REQ-014 SHALL perform a register write only when write_enable & valid & !stop.
REQ-015 SHALL drive read_result from the register selected by addr[3:2], and SHALL drive 0 when valid=0.
REQ-016 SHALL run a state machine with states IDLE, LOAD, CNT, INT.
REQ-017 SHALL move from IDLE to LOAD when EN=1, and otherwise stay in IDLE.
REQ-018 SHALL in LOAD set COUNT<=PRESET and then go to CNT.
REQ-019 SHALL in CNT:
- go to IDLE if EN=0;
- otherwise go to INT if COUNT==0;
- otherwise set COUNT<=COUNT-1 and stay in CNT.
REQ-020 SHALL in INT set the sticky flag PEND<=1, then:
- in one-shot mode, clear EN and go to IDLE;
- in auto-reload mode, go to LOAD.
REQ-021 SHALL let a performed write to CTRL or PRESET override state-machine updates in the same cycle: the register is updated, next state is IDLE, PEND<=0, and a COUNT reaching 0 in that cycle does not raise INT.
REQ-022 SHALL drive irq = IM & PEND in one-shot mode, held until a performed CTRL/PRESET write or reset.
REQ-023 SHALL in auto-reload mode clear PEND when leaving LOAD, so irq pulses for exactly 2 cycles (INT->LOAD) per period when IM=1.
REQ-024 SHALL give a period of PRESET+3 cycles from entering LOAD to re-entering LOAD.
REQ-025 SHALL take, with PRESET=0, LOAD -> CNT -> INT on consecutive cycles with no wrap of COUNT.
REQ-026 SHALL never decrement COUNT below 0, since it is only decremented when nonzero.
REQ-027 SHALL leave COUNT unchanged while in IDLE.

Reset
REQ-028 SHALL on rst=1, at any time and immediately (asynchronously), set CTRL=0, PRESET=0, COUNT=0, PEND=0 and state=IDLE, giving irq=0; read_result and valid follow their combinational definitions.
REQ-029 SHALL when reset is asserted mid-count abandon the count with no irq, and SHALL resume only after software writes CTRL.EN=1 again.

Verification
REQ-030 SHALL cover one-shot: write PRESET=5, then CTRL=0x9 -> irq rises 8 cycles after the CTRL write takes effect, stays 1, CTRL reads 0x8 (EN cleared), COUNT reads 0; a subsequent CTRL write drops irq next cycle.
REQ-031 SHALL cover auto-reload: PRESET=2, CTRL=0xB -> irq high 2 cycles every 5 cycles; COUNT sequence 2,1,0,0,0,2,...
REQ-032 SHALL cover illegal access: write to 0x8, to 0x2, or with mode!=WORD_MODE -> valid=0, registers unchanged; stop=1 with a legal write -> no change.
REQ-033 SHALL cover write collision: a CTRL write in the same cycle CNT sees COUNT==0 -> no irq, state IDLE.
REQ-034 SHALL cover reset mid-count: rst asserted at COUNT=3 -> all reads return 0, irq=0 before the next clock edge.
